// File: rtl/aes_pkg.sv
// Shared AES datapath constants, SubBytes FSM states and byte-slice helper.
package aes_pkg;

  localparam int unsigned STATE_W   = 128;
  localparam int unsigned NUM_BYTES = 16;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned BIT_IDX_W = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Byte 0 occupies the top of the state word, byte 15 the bottom.
  function automatic logic [BIT_IDX_W-1:0] byte_lsb(input logic [IDX_W-1:0] idx);
    return BIT_IDX_W'(STATE_W - BYTE_W) - {idx, 3'b000};
  endfunction

endpackage

// File: rtl/sbox.sv
// AES forward S-box as a 256-entry constant lookup table.
module sbox (
  input  logic [7:0] originalByte,
  output logic [7:0] subbedByte
);

  // Entry 0x00 sits in the top byte, so the slice base is (255 - x) * 8.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign subbedByte = SBOX_TABLE[{~originalByte, 3'b000} +: 8];

endmodule

// File: rtl/sub_bytes_serial.sv
// Byte-serial AES SubBytes: one shared S-box, 16 substitution cycles per state.
// Define SBOX_SHUFFLE_EN to start each pass at an LFSR-chosen byte offset.
module sub_bytes_serial
  import aes_pkg::*;
#(
  parameter logic [7:0] LFSR_SEED = 8'h5A
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] state_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] state_out,
  output logic               busy
);

  state_t             state;
  logic [STATE_W-1:0] data;
  logic [IDX_W-1:0]   step;
  logic [IDX_W-1:0]   idx_c;
  logic [BYTE_W-1:0]  sbox_in_c;
  logic [BYTE_W-1:0]  sbox_out_c;

`ifdef SBOX_SHUFFLE_EN
  logic [7:0]       lfsr;
  logic [IDX_W-1:0] offset;

  // Free-running x^8+x^6+x^5+x^4+1 LFSR; start offset captured on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr   <= LFSR_SEED;
      offset <= '0;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      if (state == IDLE && in_valid && in_ready) begin
        offset <= lfsr[IDX_W-1:0];
      end
    end
  end

  assign idx_c = step + offset;
`else
  logic unused_seed;
  assign unused_seed = ^LFSR_SEED;
  assign idx_c       = step;
`endif

  assign sbox_in_c = data[byte_lsb(idx_c) +: BYTE_W];
  assign state_out = data;

  sbox u_sbox (
    .originalByte (sbox_in_c),
    .subbedByte   (sbox_out_c)
  );

  // Control FSM; the handshake outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      data      <= '0;
      step      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            data     <= state_in;
            step     <= '0;
            state    <= BUSY;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        BUSY: begin
          data[byte_lsb(idx_c) +: BYTE_W] <= sbox_out_c;
          step <= step + IDX_W'(1);
          if (step == IDX_W'(NUM_BYTES - 1)) begin
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          step      <= '0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sub_bytes_serial.sv
// Scoreboard bench for sub_bytes_serial against an arithmetic GF(2^8) S-box model.
module tb_sub_bytes_serial;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;
  logic         busy;

  int checks = 0;
  int errors = 0;

  logic [127:0] sb_q[$];
  int           offs[$];
  int unsigned  edge_cnt = 0;
  int unsigned  acc_edge = 0;
  int           bcnt = 0;
  int           done_cnt = 0;
  logic         pending = 1'b0;
  logic         ov_seen = 1'b0;
  logic [127:0] cap = '0;
  int           nd;
  int           pos;

  localparam logic [127:0] VEC_29 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] EXP_29 = 128'h638293c31bfc33f5c4eeacea4bc12816;

  sub_bytes_serial #(.LFSR_SEED(8'h5A)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .state_in  (state_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .state_out (state_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // Multiplicative inverse as x^254, followed by the AES affine transform.
  function automatic logic [7:0] ref_sbox(input logic [7:0] x);
    logic [7:0] r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, x);
    return r ^ rotl(r, 1) ^ rotl(r, 2) ^ rotl(r, 3) ^ rotl(r, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] ref_state(input logic [127:0] d);
    logic [127:0] o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = ref_sbox(d[127-8*i -: 8]);
    return o;
  endfunction

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Monitor: pushes the model result on accept, pops on output handshake.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      pending = 1'b0;
    end else begin
      if (pending && busy) begin
        bcnt++;
        if (bcnt == 2) begin
          nd = 0;
          pos = 0;
          for (int i = 0; i < 16; i++) begin
            if (state_out[127-8*i -: 8] !== cap[127-8*i -: 8]) begin
              nd++;
              pos = i;
            end
          end
          check("one_byte_step", nd, 1);
`ifndef SBOX_SHUFFLE_EN
          check("start_offset", pos, 0);
`endif
          offs.push_back(pos);
        end
      end
      if (pending && out_valid && !ov_seen) begin
        ov_seen = 1'b1;
        check("latency", edge_cnt - acc_edge, 16);
        check("busy_cycles", bcnt, 16);
      end
      if (out_valid && out_ready) begin
        check("sb_nonempty", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) check("result", state_out, sb_q.pop_front());
        pending = 1'b0;
        done_cnt++;
      end
      if (in_valid && in_ready) begin
        sb_q.push_back(ref_state(state_in));
        pending  = 1'b1;
        acc_edge = edge_cnt + 1;
        bcnt     = 0;
        ov_seen  = 1'b0;
        cap      = state_in;
      end
    end
  end

  task automatic send(input logic [127:0] d);
    int t = 0;
    state_in = d;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("accept_timeout", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int t = 0;
    while (!out_valid && t < 64) begin
      @(negedge clk);
      t++;
    end
    check("out_valid_timeout", out_valid, 1);
  endtask

  function automatic logic [127:0] rand_state();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    state_in  = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_state_out", state_out, 0);

    // All-zero state
    out_ready = 1'b1;
    send('0);
    wait_out();
    check("zero_vec", state_out, {16{8'h63}});
    @(posedge clk);
    #1 check("idle_after_zero", in_ready, 1);

    // Known-answer vector
    send(VEC_29);
    wait_out();
    check("kat_vec", state_out, EXP_29);
    @(posedge clk);

    // Downstream stall with ignored upstream traffic
    #1 out_ready = 1'b0;
    send(VEC_29);
    wait_out();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      state_in = rand_state();
      @(negedge clk);
      check("stall_out_valid", out_valid, 1);
      check("stall_state_out", state_out, EXP_29);
      check("stall_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release_out_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);

    // Abort in the eighth BUSY cycle
    send(rand_state());
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_state_out", state_out, 0);
    send({16{8'hff}});
    wait_out();
    check("ff_vec", state_out, {16{8'h16}});
    @(posedge clk);

    // Back-to-back random traffic
    for (int i = 0; i < 20; i++) send(rand_state());
    wait_out();
    repeat (3) @(posedge clk);

    check("sb_drained", sb_q.size(), 0);
    check("done_count", done_cnt, 24);
`ifdef SBOX_SHUFFLE_EN
    begin
      int vary = 0;
      foreach (offs[i]) if (offs[i] != offs[0]) vary = 1;
      check("offsets_vary", vary, 1);
    end
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sub_bytes_serial.md
SUB_BYTES_SERIAL -- requirements
Module: sub_bytes_serial

Interface
REQ-001 Parameter LFSR_SEED, default 8'h5A: nonzero seed for the byte-order LFSR; used only when SBOX_SHUFFLE_EN is defined.
REQ-002 clk  input  1  single clock for the block; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  upstream (AddRoundKey) state_in is valid.
REQ-005 in_ready  output  1  block can accept a new state.
REQ-006 state_in  input  128  AES state; byte 0 = [127:120], byte 15 = [7:0].
REQ-007 out_valid  output  1  state_out holds a completed SubBytes result.
REQ-008 out_ready  input  1  downstream (ShiftRows) accepts state_out.
REQ-009 state_out  output  128  substituted state, same byte ordering as state_in.
REQ-010 busy  output  1  high while bytes are being substituted; serves as a side-channel scope trigger.

Function
REQ-011 The FSM SHALL have three states:
- IDLE: in_ready=1.
- BUSY: one byte substituted per cycle.
- DONE: out_valid=1.
REQ-012 An input SHALL be accepted on a rising edge where in_valid && in_ready; state_in is loaded into the internal 128-bit register and the FSM moves from IDLE to BUSY.
REQ-013 BUSY SHALL last exactly 16 cycles; each cycle one byte at index idx is passed through one shared S-box and written back in place on that cycle's edge.
REQ-014 The idx sequence SHALL be 0..15 unless SBOX_SHUFFLE_EN is defined.
REQ-015 After the 16th BUSY edge the FSM SHALL enter DONE; out_valid rises 16 cycles after the accepting edge.
REQ-016 In DONE, state_out and out_valid SHALL hold stable until an edge with out_ready=1; on that edge the FSM moves to IDLE.
REQ-017 in_ready SHALL be 0 in BUSY and DONE; there is no same-cycle output-and-input overlap, so the minimum spacing between accepts is 18 cycles.
REQ-018 in_valid is ignored outside IDLE, and out_ready is ignored outside DONE.
REQ-019 state_out SHALL equal the internal register at all times; its value is only guaranteed while out_valid=1.
REQ-020 busy SHALL be 1 exactly in BUSY.
REQ-021 Exactly one S-box instance SHALL exist; no other combinational substitution logic is allowed.

Reset
REQ-022 On any edge with rst=1, the block SHALL reset as follows:
- FSM enters IDLE; idx clears to 0.
- Internal register and state_out clear to 128'h0.
- out_valid=0, busy=0, in_ready=1 from the following cycle.
- LFSR reloads to LFSR_SEED.
REQ-023 Reset asserted during BUSY or DONE SHALL abort the operation with no output transfer; rst has priority over every handshake.

Configuration
REQ-024 With macro SBOX_SHUFFLE_EN defined, the byte order SHALL be randomised:
- An 8-bit maximal LFSR (x^8+x^6+x^5+x^4+1) advances once per clock.
- On the accepting edge its low 4 bits latch as start offset s.
- BUSY step k processes byte (s+k) mod 16.
- All 16 bytes are still covered exactly once, and latency is unchanged.
REQ-025 Without SBOX_SHUFFLE_EN, no LFSR logic SHALL exist and the order is fixed at 0..15.

Structure
REQ-026 Shared package aes_pkg SHALL hold:
- STATE_W=128 and NUM_BYTES=16;
- the FSM state enum (IDLE, BUSY, DONE);
- the byte-select helper mapping index to bit slice.
REQ-027 One sub-module SHALL be used: the existing sbox (ports originalByte, subbedByte), instantiated once.

Verification
REQ-028 Reset then state_in=128'h0, in_valid=1, out_ready=1 -> out_valid after 16 cycles with state_out=128'h63636363636363636363636363636363.
REQ-029 state_in=128'h00112233445566778899aabbccddeeff -> state_out=128'h638293c31bfc33f5c4eeacea4bc12816; busy high for exactly 16 cycles.
REQ-030 out_ready=0 for 10 cycles after DONE -> out_valid and state_out stay stable, in_ready=0, and a new in_valid is ignored; release -> IDLE next cycle.
REQ-031 rst=1 at BUSY cycle 8 -> next cycle IDLE, state_out=0, out_valid=0; the following input 128'hffff...ff yields 128'h1616...16 with no leakage from the aborted block.
REQ-032 With SBOX_SHUFFLE_EN defined, run 20 back-to-back random states -> every result matches the reference model, latency is always 16, and the observed start offsets are not all equal.
